pipe_cpu_fwd: RTL and testbench
===============================

PIPE_CPU_FWD -- requirements
Module: pipe_cpu_fwd

Interface
REQ-001 Parameter WIDTH, default 32: data path and register width in bits, at least 8.
REQ-002 Parameter DEPTH, default 16: instruction memory words, a power of 2 between 2 and 256.
REQ-003 Parameter NREG, default 8: register count, a power of 2 between 2 and 16.
REQ-004 The block SHALL have input clk, 1 bit, as the clock.
REQ-005 The block SHALL have input reset, 1 bit, a synchronous, active-high reset.
REQ-006 The block SHALL have input run, 1 bit: start request, sampled only in IDLE or HALTED.
REQ-007 The block SHALL have input prog_we, 1 bit: instruction memory write strobe.
REQ-008 The block SHALL have input prog_addr, clog2(DEPTH) bits: instruction memory write address.
REQ-009 The block SHALL have input prog_data, 16 bits: instruction memory write data.
REQ-010 The block SHALL have output halted, 1 bit, high in the HALTED state.
REQ-011 The block SHALL have output pc, clog2(DEPTH) bits: the current fetch address.
REQ-012 The block SHALL have output wb_valid, 1 bit, high while a register write retires.
REQ-013 The block SHALL have output wb_rd, clog2(NREG) bits: the retiring destination register.
REQ-014 The block SHALL have output wb_data, WIDTH bits: the retiring write value.
REQ-015 The block SHALL have input dbg_rsel, clog2(NREG) bits, and output dbg_rdata, WIDTH bits: a combinational register-file peek.

Function
REQ-016 Instruction format: op[15:12], rd[11:8], rs[7:4], rt[3:0], imm[7:0]; register fields SHALL use their low clog2(NREG) bits.
REQ-017 Opcodes SHALL be implemented as follows:
- 0 NOP.
- 1 LOAD: rd = zero-extended imm.
- 2 ADD: rd = rs + rt.
- 3 SUB: rd = rs - rt.
- 4 AND.
- 5 OR.
- 6 HALT.
- 7-15: NOP.
REQ-018 Arithmetic SHALL wrap modulo 2^WIDTH; no flags.
REQ-019 R0 SHALL read as 0; writes to R0 SHALL be discarded and SHALL NOT assert wb_valid.
REQ-020 Pipeline: IF (fetch into IF register), ID (decode, operand read into ID/EX), EX (ALU into EX/WB), WB (register write). Each stage register SHALL carry a valid bit.
REQ-021 wb_valid, wb_rd and wb_data SHALL be driven from the EX/WB register; the register file is written at the same edge that clears or replaces that register.
REQ-022 Register-file reads in ID SHALL bypass a same-cycle WB write (write-first).
REQ-023 State machine:
- IDLE -> RUN on run=1, with pc=0.
- RUN -> DRAIN when HALT is in ID.
- DRAIN -> HALTED when ID/EX and EX/WB are both invalid.
- HALTED -> RUN on run=1, with pc=0 and the register file retained.
REQ-024 In RUN, pc SHALL increment once per non-stalled cycle and wrap from DEPTH-1 to 0.
REQ-025 A HALT in ID SHALL become a bubble. The instruction fetched behind it SHALL be squashed, and fetching SHALL stop.
REQ-026 prog_we SHALL write the instruction memory only in IDLE or HALTED; it SHALL be ignored in RUN and DRAIN.
REQ-027 The instruction memory SHALL power up all NOP and SHALL NOT be cleared by reset.

Reset
REQ-028 Reset SHALL set the state to IDLE, pc=0, all stage valids to 0, all registers to 0, halted=0, wb_valid=0, wb_rd=0 and wb_data=0. This applies mid-run, and reset overrides run and prog_we.

Configuration
REQ-029 With macro PIPE_CPU_FWD_FORWARD_EN defined, a valid EX-stage result SHALL be forwarded to a matching ID operand (rs or rt equal to rd, rd not 0), with no stall.
REQ-030 Without PIPE_CPU_FWD_FORWARD_EN, a match SHALL hold pc and IF for one cycle and inject an ID/EX bubble; final results SHALL be identical in both builds.

Verification
REQ-031 Build with FORWARD_EN; load "1105,120A,2312,3431,6000"; pulse run at edge E0 -> wb_valid on 4 consecutive cycles; R1=5, R2=10, R3=15, R4=10; halted rises at E8.
REQ-032 Same program without FORWARD_EN -> same register values; halted rises at E10, with 2 bubbles in the wb_valid sequence.
REQ-033 Program "1007,2011,6000" -> no wb_valid for either write; R0 reads 0; R1=0.
REQ-034 prog_we during RUN writes 0x1177 to address 0 -> memory unchanged; a re-run from HALTED executes the original word.
REQ-035 Program of DEPTH NOPs with no HALT -> pc wraps DEPTH-1 -> 0 and halted stays 0.
REQ-036 Assert reset for 1 cycle mid-run after R1 is written -> next cycle: state IDLE, pc=0, R1=0, wb_valid=0.

Source files
------------

// File: rtl/pipe_cpu_fwd_if.sv
// pipe_cpu_fwd_if: bundles the control, programming, retire and debug
// signals of pipe_cpu_fwd.
//   slave  (CPU side): run, prog_we, prog_addr, prog_data, dbg_rsel in;
//                      halted, pc, wb_valid, wb_rd, wb_data, dbg_rdata out.
//   master (host side): the mirror image.
interface pipe_cpu_fwd_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int NREG  = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(NREG);

    logic             run;
    logic             prog_we;
    logic [AW-1:0]    prog_addr;
    logic [15:0]      prog_data;
    logic             halted;
    logic [AW-1:0]    pc;
    logic             wb_valid;
    logic [RW-1:0]    wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic [RW-1:0]    dbg_rsel;
    logic [WIDTH-1:0] dbg_rdata;

    modport master (
        output run, prog_we, prog_addr, prog_data, dbg_rsel,
        input  halted, pc, wb_valid, wb_rd, wb_data, dbg_rdata
    );

    modport slave (
        input  run, prog_we, prog_addr, prog_data, dbg_rsel,
        output halted, pc, wb_valid, wb_rd, wb_data, dbg_rdata
    );
endinterface

// File: rtl/pipe_cpu_fwd.sv
// pipe_cpu_fwd: four-stage (IF/ID/EX/WB) 16-bit-instruction CPU with a
// WIDTH-bit register file of NREG registers and a DEPTH-word program store.
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset
//   bus    - pipe_cpu_fwd_if.slave: run/prog_* in, halted/pc/wb_* out,
//            dbg_rsel in / dbg_rdata out (combinational register peek)
// Build option: define PIPE_CPU_FWD_FORWARD_EN to forward the EX result
// into ID operands; otherwise a dependent instruction stalls one cycle.
module pipe_cpu_fwd #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int NREG  = 8
) (
    input logic          clk,
    input logic          reset,
    pipe_cpu_fwd_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(NREG);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;
    typedef enum logic [3:0] {
        OP_NOP = 4'd0, OP_LOAD = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
        OP_AND = 4'd4, OP_OR = 4'd5, OP_HALT = 4'd6
    } op_t;

    state_t           state;
    logic             halted_r;
    logic [AW-1:0]    pc;

    // Program store powers up as all NOP and is never touched by reset.
    logic [15:0]      imem [DEPTH] = '{default: '0};
    logic [WIDTH-1:0] regs [NREG];

    logic             if_valid;
    logic [15:0]      if_instr;

    logic             idex_valid;
    logic             idex_wr;
    logic [3:0]       idex_op;
    logic [RW-1:0]    idex_rd;
    logic [WIDTH-1:0] idex_a;
    logic [WIDTH-1:0] idex_b;

    logic             exwb_valid;
    logic [RW-1:0]    exwb_rd;
    logic [WIDTH-1:0] exwb_data;

    // Decode of the IF register (the ID stage).
    logic [3:0]       id_op;
    logic [RW-1:0]    id_rd, id_rs, id_rt;
    logic [7:0]       id_imm;
    logic             id_reads, id_writes, id_halt, stall;
    logic [WIDTH-1:0] rs_val, rt_val, ex_result;
    logic             unused_fields;

    assign id_op  = if_instr[15:12];
    assign id_rd  = if_instr[8 +: RW];
    assign id_rs  = if_instr[4 +: RW];
    assign id_rt  = if_instr[0 +: RW];
    assign id_imm = if_instr[7:0];
    assign unused_fields = ^if_instr;

    assign id_reads  = id_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    // R0 writes are dropped at decode so they never reach wb_valid.
    assign id_writes = (id_op inside {OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR})
                       && (id_rd != '0);
    assign id_halt   = (state == S_RUN) && if_valid && (id_op == OP_HALT);

    always_comb begin
        ex_result = '0;
        case (idex_op)
            OP_LOAD: ex_result = idex_a;
            OP_ADD:  ex_result = idex_a + idex_b;
            OP_SUB:  ex_result = idex_a - idex_b;
            OP_AND:  ex_result = idex_a & idex_b;
            OP_OR:   ex_result = idex_a | idex_b;
            default: ex_result = '0;
        endcase
    end

    // Operand read: register file, then same-cycle WB write, then (if
    // enabled) the EX result, which is the youngest value.
    always_comb begin
        rs_val = regs[id_rs];
        rt_val = regs[id_rt];
        if (exwb_valid && exwb_rd == id_rs) rs_val = exwb_data;
        if (exwb_valid && exwb_rd == id_rt) rt_val = exwb_data;
`ifdef PIPE_CPU_FWD_FORWARD_EN
        if (idex_valid && idex_wr && idex_rd == id_rs) rs_val = ex_result;
        if (idex_valid && idex_wr && idex_rd == id_rt) rt_val = ex_result;
`endif
        if (id_rs == '0) rs_val = '0;
        if (id_rt == '0) rt_val = '0;
    end

`ifdef PIPE_CPU_FWD_FORWARD_EN
    assign stall = 1'b0;
`else
    assign stall = (state == S_RUN) && if_valid && id_reads && idex_valid &&
                   idex_wr && (idex_rd == id_rs || idex_rd == id_rt);
`endif

    always_ff @(posedge clk) begin
        if (!reset && bus.prog_we && (state == S_IDLE || state == S_HALTED))
            imem[bus.prog_addr] <= bus.prog_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            halted_r   <= 1'b0;
            pc         <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            idex_valid <= 1'b0;
            idex_wr    <= 1'b0;
            idex_op    <= '0;
            idex_rd    <= '0;
            idex_a     <= '0;
            idex_b     <= '0;
            exwb_valid <= 1'b0;
            exwb_rd    <= '0;
            exwb_data  <= '0;
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (exwb_valid) regs[exwb_rd] <= exwb_data;

            exwb_valid <= idex_valid && idex_wr;
            exwb_rd    <= idex_rd;
            exwb_data  <= ex_result;

            // HALT and stalls both leave a bubble in ID/EX.
            idex_valid <= if_valid && !stall && (id_op != OP_HALT);
            idex_wr    <= id_writes;
            idex_op    <= id_op;
            idex_rd    <= id_rd;
            idex_a     <= (id_op == OP_LOAD) ? WIDTH'(id_imm) : rs_val;
            idex_b     <= rt_val;

            case (state)
                S_IDLE, S_HALTED: begin
                    if (bus.run) begin
                        state    <= S_RUN;
                        halted_r <= 1'b0;
                        pc       <= '0;
                    end
                end
                S_RUN: begin
                    if (id_halt) begin
                        state    <= S_DRAIN;
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        if_instr <= imem[pc];
                        if_valid <= 1'b1;
                        pc       <= pc + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if_valid <= 1'b0;
                    if (!idex_valid && !exwb_valid) begin
                        state    <= S_HALTED;
                        halted_r <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.halted    = halted_r;
    assign bus.pc        = pc;
    assign bus.wb_valid  = exwb_valid;
    assign bus.wb_rd     = exwb_rd;
    assign bus.wb_data   = exwb_data;
    assign bus.dbg_rdata = regs[bus.dbg_rsel];
endmodule

// File: tb/tb_pipe_cpu_fwd.sv
// tb_pipe_cpu_fwd: directed bench for pipe_cpu_fwd (default parameters).
// Expected retire timing follows PIPE_CPU_FWD_FORWARD_EN when defined.
module tb_pipe_cpu_fwd;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int NREG  = 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = $clog2(NREG);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipe_cpu_fwd_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREG(NREG)) bus ();

    pipe_cpu_fwd #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREG(NREG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input int r, input logic [WIDTH-1:0] exp);
        bus.dbg_rsel = RW'(r);
        #1;
        check(tag, bus.dbg_rdata, exp);
    endtask

    task automatic load(input int addr, input logic [15:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = AW'(addr);
        bus.prog_data = data;
        step();
        bus.prog_we   = 1'b0;
    endtask

    task automatic pulse_run();
        bus.run = 1'b1;
        step();
        bus.run = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_halted(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (bus.halted) break;
            step();
        end
        check(tag, bus.halted, 1);
    endtask

    logic [10:1] wbv, hv, exp_wbv, exp_hv;
    int wb_cnt;

    initial begin
        bus.run = 1'b0;
        bus.prog_we = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.dbg_rsel = '0;
`ifdef PIPE_CPU_FWD_FORWARD_EN
        exp_wbv = 10'b0000111100;
        exp_hv  = 10'b1110000000;
`else
        exp_wbv = 10'b0010101100;
        exp_hv  = 10'b1000000000;
`endif
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_pc", bus.pc, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_wb_rd", bus.wb_rd, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check_reg("rst_r1", 1, 0);

        // Program A, with an ignored program write during RUN
        load(0, 16'h1105);
        load(1, 16'h120A);
        load(2, 16'h2312);
        load(3, 16'h3431);
        load(4, 16'h6000);
        pulse_run();
        check("a_pc_e0", bus.pc, 0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) begin
                bus.prog_we   = 1'b1;
                bus.prog_addr = '0;
                bus.prog_data = 16'h1177;
            end
            step();
            bus.prog_we = 1'b0;
            wbv[k] = bus.wb_valid;
            hv[k]  = bus.halted;
            if (k == 1) check("a_pc_e1", bus.pc, 1);
            if (k == 3) begin
                check("a_wb_rd_e3", bus.wb_rd, 1);
                check("a_wb_data_e3", bus.wb_data, 5);
            end
        end
        check("a_wb_pattern", wbv, exp_wbv);
        check("a_halted_pattern", hv, exp_hv);
        check_reg("a_r1", 1, 5);
        check_reg("a_r2", 2, 10);
        check_reg("a_r3", 3, 15);
        check_reg("a_r4", 4, 10);

        // Re-run from HALTED must execute the original word 0
        pulse_run();
        check("rerun_pc", bus.pc, 0);
        check("rerun_halted", bus.halted, 0);
        step();
        step();
        step();
        check("rerun_wb_valid", bus.wb_valid, 1);
        check("rerun_wb_rd", bus.wb_rd, 1);
        check("rerun_wb_data", bus.wb_data, 5);
        wait_halted("rerun_halts");
        check_reg("rerun_r4", 4, 10);

        // Program B: writes to R0 are discarded silently
        do_reset();
        load(0, 16'h1007);
        load(1, 16'h2011);
        load(2, 16'h6000);
        pulse_run();
        wb_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.halted) break;
            if (bus.wb_valid) wb_cnt++;
            step();
        end
        check("b_halts", bus.halted, 1);
        check("b_wb_count", wb_cnt, 0);
        check_reg("b_r0", 0, 0);
        check_reg("b_r1", 1, 0);

        // Program C: AND, OR, wrapping SUB, undefined opcode as NOP
        load(0, 16'h110C);
        load(1, 16'h120A);
        load(2, 16'h4312);
        load(3, 16'h5412);
        load(4, 16'h3521);
        load(5, 16'h7111);
        load(6, 16'h6000);
        pulse_run();
        wait_halted("c_halts");
        check_reg("c_r1", 1, 32'h0000_000C);
        check_reg("c_r3_and", 3, 32'h0000_0008);
        check_reg("c_r4_or", 4, 32'h0000_000E);
        check_reg("c_r5_wrap", 5, 32'hFFFF_FFFE);

        // Program D: all NOPs, pc wraps and never halts
        do_reset();
        for (int a = 0; a < DEPTH; a++) load(a, 16'h0000);
        pulse_run();
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 15) check("d_pc_15", bus.pc, 15);
            if (k == 16) check("d_pc_wrap", bus.pc, 0);
        end
        check("d_not_halted", bus.halted, 0);

        // Program E: reset mid-run after R1 is written
        do_reset();
        load(0, 16'h1105);
        load(1, 16'h120A);
        load(2, 16'h2312);
        load(3, 16'h3431);
        load(4, 16'h6000);
        pulse_run();
        step();
        step();
        step();
        step();
        check_reg("e_r1_before", 1, 5);
        do_reset();
        check("e_pc", bus.pc, 0);
        check("e_wb_valid", bus.wb_valid, 0);
        check("e_halted", bus.halted, 0);
        check_reg("e_r1_cleared", 1, 0);
        step();
        step();
        step();
        check("e_idle_pc", bus.pc, 0);
        check("e_idle_wb_valid", bus.wb_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
